// File: rtl/pmbist_fail_log_if.sv
// Compare-side bus of the PMBIST fail logger: run indication, compare strobe,
// access coordinates and per-memory fail/enable masks.
interface pmbist_fail_log_if #(
    parameter int MEM_NUM    = 4,
    parameter int ADDR_X     = 2,
    parameter int ADDR_Y     = 2,
    parameter int INST_NUM_W = 4
);
    logic                  i_run;
    logic                  i_comp_en;
    logic [INST_NUM_W-1:0] i_inst;
    logic [ADDR_X-1:0]     i_addr_x;
    logic [ADDR_Y-1:0]     i_addr_y;
    logic [MEM_NUM-1:0]    i_fail_flags;
    logic [MEM_NUM-1:0]    i_mem_en;

    modport master (
        output i_run, i_comp_en, i_inst, i_addr_x, i_addr_y, i_fail_flags, i_mem_en
    );

    modport slave (
        input  i_run, i_comp_en, i_inst, i_addr_x, i_addr_y, i_fail_flags, i_mem_en
    );
endinterface

// File: rtl/pmbist_fail_log.sv
// Per-memory PMBIST fail logger with sticky bit, saturating count and first-fail record,
// read out through a capture/shift chain. Optional stop-on-fail: PMBIST_STOP_ON_FAIL_EN.
module pmbist_fail_log #(
    parameter int MEM_NUM    = 4,
    parameter int ADDR_X     = 2,
    parameter int ADDR_Y     = 2,
    parameter int INST_NUM_W = 4,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    pmbist_fail_log_if.slave   cmp,
    input  logic               select,
    input  logic               capture_en,
    input  logic               shift_en,
    input  logic               si,
    output logic               so,
    output logic [MEM_NUM-1:0] o_fail_vec,
    output logic               o_any_fail,
    output logic               o_halt
);
    localparam int REC_W   = 1 + CNT_W + INST_NUM_W + ADDR_X + ADDR_Y;
    localparam int CHAIN_W = MEM_NUM * REC_W;

    typedef enum logic [1:0] {IDLE, LOG, HOLD} state_t;

    state_t                state, state_nxt;
    logic                  rec_clr;
    logic                  log_en;
    logic                  halt;
    logic [MEM_NUM-1:0]    hit;
    logic [MEM_NUM-1:0]    sticky;
    logic [CNT_W-1:0]      cnt     [MEM_NUM];
    logic [INST_NUM_W-1:0] first_i [MEM_NUM];
    logic [ADDR_X-1:0]     first_x [MEM_NUM];
    logic [ADDR_Y-1:0]     first_y [MEM_NUM];
    logic [CHAIN_W-1:0]    live;
    logic [CHAIN_W-1:0]    chain;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rec_clr   = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (cmp.i_run) begin
                    state_nxt = LOG;
                    rec_clr   = 1'b1;
                end
            end
            LOG: begin
                if (!cmp.i_run) state_nxt = HOLD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign log_en = (state == LOG) && cmp.i_comp_en && !halt;
    assign hit    = {MEM_NUM{log_en}} & cmp.i_mem_en & cmp.i_fail_flags;

`ifdef PMBIST_STOP_ON_FAIL_EN
    logic halt_nxt;

    // Halt latches on the first logged fail and drops as soon as the run leaves LOG.
    always_comb halt_nxt = (state_nxt == LOG) && (halt || (|hit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) halt <= 1'b0;
        else     halt <= halt_nxt;
    end
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
            for (int m = 0; m < MEM_NUM; m++) begin
                cnt[m]     <= '0;
                first_i[m] <= '0;
                first_x[m] <= '0;
                first_y[m] <= '0;
            end
        end else if (rec_clr) begin
            sticky <= '0;
            for (int m = 0; m < MEM_NUM; m++) begin
                cnt[m]     <= '0;
                first_i[m] <= '0;
                first_x[m] <= '0;
                first_y[m] <= '0;
            end
        end else begin
            for (int m = 0; m < MEM_NUM; m++) begin
                if (hit[m]) begin
                    cnt[m] <= sat_inc(cnt[m]);
                    if (!sticky[m]) begin
                        sticky[m]  <= 1'b1;
                        first_i[m] <= cmp.i_inst;
                        first_x[m] <= cmp.i_addr_x;
                        first_y[m] <= cmp.i_addr_y;
                    end
                end
            end
        end
    end

    // Record LSB-first: sticky, count, inst, x, y; channel 0 at the chain LSBs.
    always_comb begin
        live = '0;
        for (int m = 0; m < MEM_NUM; m++)
            live[m*REC_W +: REC_W] = {first_y[m], first_x[m], first_i[m], cnt[m], sticky[m]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      chain <= '0;
        else if (select & capture_en) chain <= live;
        else if (select & shift_en)   chain <= {si, chain[CHAIN_W-1:1]};
    end

    assign so         = chain[0];
    assign o_fail_vec = sticky;
    assign o_any_fail = |sticky;
    assign o_halt     = halt;
endmodule

// File: tb/tb_pmbist_fail_log.sv
// Directed self-checking bench for pmbist_fail_log (4 channels, 17-bit records, 68-bit chain).
module tb_pmbist_fail_log;
    localparam int MEM_NUM = 4;
    localparam int REC_W   = 17;
    localparam int CW      = MEM_NUM * REC_W;

`ifdef PMBIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic select, capture_en, shift_en, si;
    logic so;
    logic [MEM_NUM-1:0] o_fail_vec;
    logic o_any_fail;
    logic o_halt;

    int n_tests = 0;
    int n_fail  = 0;

    pmbist_fail_log_if #(.MEM_NUM(4), .ADDR_X(2), .ADDR_Y(2), .INST_NUM_W(4)) bus ();

    pmbist_fail_log #(
        .MEM_NUM(4), .ADDR_X(2), .ADDR_Y(2), .INST_NUM_W(4), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmp        (bus),
        .select     (select),
        .capture_en (capture_en),
        .shift_en   (shift_en),
        .si         (si),
        .so         (so),
        .o_fail_vec (o_fail_vec),
        .o_any_fail (o_any_fail),
        .o_halt     (o_halt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [REC_W-1:0] mk_rec(input logic s, input logic [7:0] c,
                                                input logic [3:0] ins, input logic [1:0] x,
                                                input logic [1:0] y);
        return {y, x, ins, c, s};
    endfunction

    function automatic logic [REC_W-1:0] rec_of(input logic [CW-1:0] v, input int m);
        return v[m*REC_W +: REC_W];
    endfunction

    task automatic drive_cmp(input logic [3:0] f, input logic [3:0] ins,
                             input logic [1:0] x, input logic [1:0] y);
        bus.i_comp_en    = 1'b1;
        bus.i_fail_flags = f;
        bus.i_inst       = ins;
        bus.i_addr_x     = x;
        bus.i_addr_y     = y;
    endtask

    task automatic set_run(input logic r);
        @(negedge clk);
        bus.i_run     = r;
        bus.i_comp_en = 1'b0;
    endtask

    task automatic read_chain(output logic [CW-1:0] v);
        @(negedge clk);
        bus.i_comp_en = 1'b0;
        select = 1'b1; capture_en = 1'b1; shift_en = 1'b0; si = 1'b0;
        for (int i = 0; i < CW; i++) begin
            @(negedge clk);
            v[i]       = so;
            capture_en = 1'b0;
            shift_en   = (i < CW - 1);
        end
        select = 1'b0; shift_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [CW-1:0] v;
        rst = 1'b1;
        bus.i_run = 1'($urandom); bus.i_comp_en = 1'($urandom);
        bus.i_inst = 4'($urandom); bus.i_addr_x = 2'($urandom); bus.i_addr_y = 2'($urandom);
        bus.i_fail_flags = 4'($urandom); bus.i_mem_en = 4'($urandom);
        select = 1'($urandom); capture_en = 1'($urandom); shift_en = 1'($urandom); si = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (o_fail_vec !== 4'b0) begin n_fail++; $display("FAIL reset_fail_vec: got %b required 0000", o_fail_vec); end
        n_tests++; if (o_any_fail !== 1'b0) begin n_fail++; $display("FAIL reset_any_fail: got %b required 0", o_any_fail); end
        n_tests++; if (so !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b required 0", so); end
        n_tests++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b required 0", o_halt); end
        bus.i_run = 1'b0; bus.i_comp_en = 1'b0; bus.i_fail_flags = '0; bus.i_mem_en = 4'b1111;
        bus.i_inst = '0; bus.i_addr_x = '0; bus.i_addr_y = '0;
        select = 1'b0; capture_en = 1'b0; shift_en = 1'b0; si = 1'b0;
        @(negedge clk); rst = 1'b0;
        read_chain(v);
        n_tests++; if (v !== '0) begin n_fail++; $display("FAIL reset_chain: got %h required 0", v); end
    endtask

    task automatic test_single_fail();
        logic [CW-1:0] v;
        set_run(1'b1);
        @(negedge clk); drive_cmp(4'b0100, 4'd5, 2'd1, 2'd3);
        @(negedge clk); bus.i_comp_en = 1'b0; bus.i_run = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b0100) begin n_fail++; $display("FAIL single_fail_vec: got %b required 0100", o_fail_vec); end
        n_tests++; if (o_any_fail !== 1'b1) begin n_fail++; $display("FAIL single_any_fail: got %b required 1", o_any_fail); end
        read_chain(v);
        n_tests++; if (rec_of(v, 2) !== mk_rec(1'b1, 8'd1, 4'd5, 2'd1, 2'd3)) begin n_fail++; $display("FAIL single_rec2: got %h required %h", rec_of(v, 2), mk_rec(1'b1, 8'd1, 4'd5, 2'd1, 2'd3)); end
        n_tests++; if (rec_of(v, 0) !== '0) begin n_fail++; $display("FAIL single_rec0: got %h required 0", rec_of(v, 0)); end
        n_tests++; if (rec_of(v, 1) !== '0) begin n_fail++; $display("FAIL single_rec1: got %h required 0", rec_of(v, 1)); end
        n_tests++; if (rec_of(v, 3) !== '0) begin n_fail++; $display("FAIL single_rec3: got %h required 0", rec_of(v, 3)); end
    endtask

    task automatic test_first_fail();
        logic [CW-1:0] v;
        logic [7:0] exp_cnt;
        exp_cnt = STOP ? 8'd1 : 8'd3;
        // A compare on the run-start edge is discarded; the prior ch2 record is cleared there too.
        @(negedge clk); bus.i_run = 1'b1; drive_cmp(4'b0001, 4'd9, 2'd1, 2'd1);
        @(negedge clk);
        n_tests++; if (o_fail_vec !== 4'b0000) begin n_fail++; $display("FAIL start_discard_vec: got %b required 0000", o_fail_vec); end
        drive_cmp(4'b0001, 4'd2, 2'd0, 2'd1);
        @(negedge clk); drive_cmp(4'b0001, 4'd3, 2'd2, 2'd2);
        @(negedge clk); drive_cmp(4'b0001, 4'd4, 2'd3, 2'd3);
        @(negedge clk); bus.i_comp_en = 1'b0; bus.i_run = 1'b0;
        read_chain(v);
        n_tests++; if (rec_of(v, 0) !== mk_rec(1'b1, exp_cnt, 4'd2, 2'd0, 2'd1)) begin n_fail++; $display("FAIL first_rec0: got %h required %h", rec_of(v, 0), mk_rec(1'b1, exp_cnt, 4'd2, 2'd0, 2'd1)); end
        n_tests++; if (rec_of(v, 2) !== '0) begin n_fail++; $display("FAIL rerun_clear_rec2: got %h required 0", rec_of(v, 2)); end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] v;
        logic [7:0] exp_cnt;
        exp_cnt = STOP ? 8'd1 : 8'd255;
        set_run(1'b1);
        @(negedge clk); drive_cmp(4'b0010, 4'd6, 2'd2, 2'd1);
        repeat (300) @(negedge clk);
        bus.i_comp_en = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b0010) begin n_fail++; $display("FAIL sat_fail_vec: got %b required 0010", o_fail_vec); end
        read_chain(v);
        n_tests++; if (rec_of(v, 1) !== mk_rec(1'b1, exp_cnt, 4'd6, 2'd2, 2'd1)) begin n_fail++; $display("FAIL sat_rec1: got %h required %h", rec_of(v, 1), mk_rec(1'b1, exp_cnt, 4'd6, 2'd2, 2'd1)); end
        n_tests++; if (rec_of(v, 0) !== '0) begin n_fail++; $display("FAIL sat_rec0: got %h required 0", rec_of(v, 0)); end
        set_run(1'b0);
    endtask

    task automatic test_mask();
        logic [CW-1:0] v;
        bus.i_mem_en = 4'b1110;
        set_run(1'b1);
        @(negedge clk); drive_cmp(4'b0001, 4'd1, 2'd1, 2'd1);
        @(negedge clk); bus.i_comp_en = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b0000) begin n_fail++; $display("FAIL mask_fail_vec: got %b required 0000", o_fail_vec); end
        n_tests++; if (o_any_fail !== 1'b0) begin n_fail++; $display("FAIL mask_any_fail: got %b required 0", o_any_fail); end
        @(negedge clk); drive_cmp(4'b1111, 4'd7, 2'd2, 2'd0);
        @(negedge clk); bus.i_comp_en = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b1110) begin n_fail++; $display("FAIL multi_fail_vec: got %b required 1110", o_fail_vec); end
        set_run(1'b0);
        read_chain(v);
        n_tests++; if (rec_of(v, 0) !== '0) begin n_fail++; $display("FAIL mask_rec0: got %h required 0", rec_of(v, 0)); end
        for (int m = 1; m < MEM_NUM; m++) begin
            n_tests++; if (rec_of(v, m) !== mk_rec(1'b1, 8'd1, 4'd7, 2'd2, 2'd0)) begin n_fail++; $display("FAIL multi_rec%0d: got %h required %h", m, rec_of(v, m), mk_rec(1'b1, 8'd1, 4'd7, 2'd2, 2'd0)); end
        end
        bus.i_mem_en = 4'b1111;
    endtask

    task automatic test_reset_mid_log();
        logic [CW-1:0] v;
        set_run(1'b1);
        @(negedge clk); drive_cmp(4'b1000, 4'd1, 2'd1, 2'd1);
        @(negedge clk); bus.i_comp_en = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b1000) begin n_fail++; $display("FAIL midlog_pre_vec: got %b required 1000", o_fail_vec); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (o_fail_vec !== 4'b0000) begin n_fail++; $display("FAIL midlog_rst_vec: got %b required 0000", o_fail_vec); end
        n_tests++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL midlog_rst_halt: got %b required 0", o_halt); end
        bus.i_run = 1'b0;
        @(negedge clk); rst = 1'b0;
        // Back in IDLE: compares without a run must not log.
        @(negedge clk); drive_cmp(4'b1111, 4'd3, 2'd3, 2'd3);
        @(negedge clk); bus.i_comp_en = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b0000) begin n_fail++; $display("FAIL idle_nolog_vec: got %b required 0000", o_fail_vec); end
        read_chain(v);
        n_tests++; if (v !== '0) begin n_fail++; $display("FAIL midlog_chain: got %h required 0", v); end
    endtask

    task automatic test_stop_on_fail();
        logic [CW-1:0] v;
        logic [7:0] exp_cnt;
        exp_cnt = STOP ? 8'd1 : 8'd6;
        set_run(1'b1);
        @(negedge clk); drive_cmp(4'b1000, 4'd1, 2'd0, 2'd2);
        @(negedge clk);
        n_tests++; if (o_halt !== STOP) begin n_fail++; $display("FAIL halt_rise: got %b required %b", o_halt, STOP); end
        drive_cmp(4'b1000, 4'd6, 2'd3, 2'd3);
        repeat (5) @(negedge clk);
        bus.i_comp_en = 1'b0;
        n_tests++; if (o_halt !== STOP) begin n_fail++; $display("FAIL halt_hold: got %b required %b", o_halt, STOP); end
        read_chain(v);
        n_tests++; if (rec_of(v, 3) !== mk_rec(1'b1, exp_cnt, 4'd1, 2'd0, 2'd2)) begin n_fail++; $display("FAIL stop_rec3: got %h required %h", rec_of(v, 3), mk_rec(1'b1, exp_cnt, 4'd1, 2'd0, 2'd2)); end
        set_run(1'b0);
        @(negedge clk);
        n_tests++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL halt_drop: got %b required 0", o_halt); end
        // HOLD keeps the records frozen.
        drive_cmp(4'b0001, 4'd2, 2'd2, 2'd2);
        @(negedge clk); bus.i_comp_en = 1'b0;
        n_tests++; if (o_fail_vec !== 4'b1000) begin n_fail++; $display("FAIL hold_frozen_vec: got %b required 1000", o_fail_vec); end
    endtask

    initial begin
        test_reset();
        test_single_fail();
        test_first_fail();
        test_saturation();
        test_mask();
        test_reset_mid_log();
        test_stop_on_fail();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pmbist_fail_log.md
# pmbist_fail_log

Parametrised per-memory fail logger for the PMBIST controller. It sits between the memory comparators and the serial test-data interface. During a BIST run it keeps, for every memory channel, a sticky fail bit, a saturating fail count and the first-fail record (instruction pointer, X and Y address). It exposes the results on a capture/shift chain that plugs into the existing setup/result scan path.

## Interface
- MEM_NUM, 4: number of memory channels logged
- ADDR_X, 2: X address width
- ADDR_Y, 2: Y address width
- INST_NUM_W, 4: instruction pointer width
- CNT_W, 8: per-channel fail counter width
- Derived: REC_W = 1+CNT_W+INST_NUM_W+ADDR_X+ADDR_Y; CHAIN_W = MEM_NUM*REC_W
- clk  in  1  sole clock
- Reset  in  1  asynchronous, active-high reset
- i_run  in  1  BIST run indication from the run FSM
- i_comp_en  in  1  compare strobe; fail flags valid this cycle
- i_inst  in  INST_NUM_W  instruction pointer of the compared access
- i_addr_x  in  ADDR_X  X address of the compared access
- i_addr_y  in  ADDR_Y  Y address of the compared access
- i_fail_flags  in  MEM_NUM  per-memory miscompare
- i_mem_en  in  MEM_NUM  per-memory logging enable mask
- select  in  1  chain selected
- capture_en  in  1  load chain from live records
- shift_en  in  1  shift chain one bit
- si  in  1  serial in
- so  out  1  serial out, chain bit 0
- o_fail_vec  out  MEM_NUM  sticky fail bits
- o_any_fail  out  1  OR of o_fail_vec
- o_halt  out  1  stop request (see Configuration)

## Operation
- Reset: all records, chain, state are cleared; all outputs are 0; the state is IDLE.
- States: IDLE (post-reset, empty), LOG, HOLD.
- IDLE or HOLD, with i_run=1 -> LOG. All records are cleared on this edge. Any compare in that same cycle is discarded.
- LOG with i_run=0 -> HOLD. In HOLD, records are frozen.
- Logging happens only in LOG, on cycles with i_comp_en=1. For each m with i_mem_en[m] & i_fail_flags[m]:
  - count[m] increments, saturating at 2^CNT_W-1.
  - If sticky[m]=0: set sticky[m] and capture {i_inst, i_addr_x, i_addr_y} into first[m].
  - If sticky[m] is already 1: only the count changes; first[m] is unchanged.
- A masked channel never updates, regardless of its fail flag.
- Channels update independently; simultaneous fails on several channels are all logged in the same cycle.
- Chain (CHAIN_W bits, independent of state):
  - select&capture_en loads the live records.
  - Otherwise select&shift_en shifts right: si enters at the MSB, and so = chain[0].
  - Capture has priority over shift.
- Chain layout: channel 0 occupies the LSBs. Within a record, LSB-first: sticky, count, inst, x, y.

## Timing
- Fail flagged at edge N (i_comp_en=1) -> o_fail_vec/o_any_fail/count reflect it after edge N; visible in cycle N+1.
- o_fail_vec is driven directly from registers; o_any_fail is combinational OR of registered bits.
- Capture at edge N -> so shows channel 0 sticky bit in cycle N+1. Each shift edge advances one bit.
- Reset mid-LOG: immediate clear to IDLE. A new run starts clean.
- Capture during LOG is legal and snapshots the current values. Logging continues unaffected.

## Configuration
- PMBIST_STOP_ON_FAIL_EN defined:
  - o_halt rises on the edge that logs the first fail of the run (any channel) and stays high until the state leaves LOG, or until Reset.
  - While o_halt=1, further compares are ignored (counts freeze).
- Not defined: o_halt is tied 0 and logging continues for the whole run.

## Test plan
- Reset with random inputs -> o_fail_vec=0, o_any_fail=0, so=0, o_halt=0. A capture plus 68 shifts returns all zeros.
- Run, one strobe with i_fail_flags=4'b0100, i_inst=5, x=1, y=3 -> o_fail_vec=4'b0100 next cycle. After i_run drops, capture and 68 shifts give record 2 = {sticky 1, count 1, inst 5, x 1, y 3}; records 0/1/3 are zero.
- Three fail strobes on channel 0 at (inst 2,x 0,y 1), (3,2,2), (4,3,3) -> count0=3, first0={2,0,1}.
- 300 strobes failing channel 1 -> count1=255 (saturated), sticky1=1.
- i_mem_en=4'b1110, fail on channel 0 -> o_fail_vec=0. A second run clears a prior channel-2 fail on the i_run rise edge. Reset mid-LOG -> all zero.
- With PMBIST_STOP_ON_FAIL_EN: fail on channel 3, then 5 more fail strobes -> o_halt=1 from the next cycle and count3=1. Dropping i_run -> o_halt=0.
